// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the instruction sequencer.
// Holds the FSM state enum, queue geometry, instruction width and timestep codes.
package instr_sequencer_pkg;

    localparam int unsigned INSTR_W    = 10;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PTR_W      = 2;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned T_W        = 2;
    localparam int unsigned RET_W      = 8;

    localparam logic [T_W-1:0] T0    = 2'd0;
    localparam logic [T_W-1:0] T1    = 2'd1;
    localparam logic [T_W-1:0] T2    = 2'd2;
    localparam logic [T_W-1:0] T3    = 2'd3;
    localparam logic [T_W-1:0] T_MAX = T3;

    typedef logic [INSTR_W-1:0] instr_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_ERROR = 2'd3
    } state_e;

endpackage

// File: rtl/instr_fifo.sv
// 4-deep instruction queue with occupancy count.
// Ports: clk, resetn (async active-low), push/din (write), pop (read),
//        dout (current head, combinational), count (occupancy 0..4).
module instr_fifo
    import instr_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  instr_t           din,
    input  logic             pop,
    output instr_t           dout,
    output logic [CNT_W-1:0] count
);

    instr_t           mem_q [FIFO_DEPTH];
    instr_t           mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Guarded push/pop; pointers wrap naturally at 2 bits.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_push  = push && (count_q < CNT_W'(FIFO_DEPTH));
        do_pop   = pop && (count_q != '0);
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: queues loader words and steps each one through
// FETCH and up to three EXEC timesteps, waiting for done from the control circuit.
// Ports: clk, resetn (async active-low), run, instr_in/instr_valid/instr_ready (loader side),
//        done, instr, t (control side), busy, err, fifo_count, retired (status).
module instr_sequencer
    import instr_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               run,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic               done,
    output logic [INSTR_W-1:0] instr,
    output logic [T_W-1:0]     t,
    output logic               busy,
    output logic               err,
    output logic [CNT_W-1:0]   fifo_count,
    output logic [RET_W-1:0]   retired
);

    state_e           state_q, state_d;
    logic [T_W-1:0]   t_q, t_d;
    instr_t           cur_instr_q, cur_instr_d;
    logic             err_q, err_d;
    logic [RET_W-1:0] retired_q, retired_d;
    logic             push_c, pop_c;
    instr_t           fifo_head;

    instr_fifo u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push_c),
        .din    (instr_in),
        .pop    (pop_c),
        .dout   (fifo_head),
        .count  (fifo_count)
    );

    // Ready depends only on registered occupancy, never on a same-cycle pop.
    assign instr_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign push_c      = instr_valid && instr_ready;

    // Next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        cur_instr_d = cur_instr_q;
        err_d       = err_q;
        retired_d   = retired_q;
        pop_c       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                t_d = T0;
                if (run && (fifo_count != '0)) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                pop_c       = 1'b1;
                cur_instr_d = fifo_head;
                t_d         = T1;
                state_d     = ST_EXEC;
            end
            ST_EXEC: begin
                if (done) begin
                    retired_d = retired_q + RET_W'(1);
                    t_d       = T0;
                    state_d   = (run && (fifo_count != '0)) ? ST_FETCH : ST_IDLE;
                end else if (t_q == T_MAX) begin
                    // Control circuit never signalled completion: latch the fault.
                    t_d     = T0;
                    err_d   = 1'b1;
                    state_d = ST_ERROR;
                end else begin
                    case (t_q)
                        T0:      t_d = T1;
                        T1:      t_d = T2;
                        default: t_d = T3;
                    endcase
                end
            end
            ST_ERROR: begin
                t_d   = T0;
                err_d = 1'b1;
            end
            default: begin
                t_d     = T0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            t_q         <= T0;
            cur_instr_q <= '0;
            err_q       <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            cur_instr_q <= cur_instr_d;
            err_q       <= err_d;
            retired_q   <= retired_d;
        end
    end

    // The FIFO head is shown during FETCH so the control circuit sees it one cycle early.
    assign instr   = (state_q == ST_FETCH) ? fifo_head : cur_instr_q;
    assign t       = t_q;
    assign busy    = (state_q == ST_FETCH) || (state_q == ST_EXEC);
    assign err     = err_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus randomized
// traffic compared against a queue-based behavioural model.
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       resetn;
    logic       run;
    logic [9:0] instr_in;
    logic       instr_valid;
    logic       instr_ready;
    logic       done;
    logic [9:0] instr;
    logic [1:0] t;
    logic       busy;
    logic       err;
    logic [2:0] fifo_count;
    logic [7:0] retired;

    int checks = 0;
    int errors = 0;

    // Model: queued words, whether an instruction is in flight, and how many
    // cycles it has spent since its fetch cycle (0 = fetch, 1..3 = execute).
    int mq[$];
    bit m_act;
    int m_age;
    bit m_err;
    int m_ret;
    int m_cur;
    int tgt;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk         (clk),
        .resetn      (resetn),
        .run         (run),
        .instr_in    (instr_in),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .done        (done),
        .instr       (instr),
        .t           (t),
        .busy        (busy),
        .err         (err),
        .fifo_count  (fifo_count),
        .retired     (retired)
    );

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic m_reset();
        mq.delete();
        m_act = 0; m_age = 0; m_err = 0; m_ret = 0; m_cur = 0;
    endtask

    function automatic int exp_t();
        return m_act ? m_age : 0;
    endfunction

    function automatic int exp_instr();
        return (m_act && m_age == 0) ? mq[0] : m_cur;
    endfunction

    // Drive one cycle of inputs, advance the clock, and advance the model.
    task automatic cycle(input bit r, input bit v, input int w, input bit d);
        bit do_push;
        run = r; instr_valid = v; instr_in = 10'(w); done = d;
        @(posedge clk);
        do_push = v && (mq.size() < 4);
        if (!m_err) begin
            if (!m_act) begin
                if (r && mq.size() > 0) begin m_act = 1; m_age = 0; end
            end else if (m_age == 0) begin
                m_cur = mq.pop_front();
                m_age = 1;
            end else if (d) begin
                m_ret++;
                if (r && mq.size() > 0) m_age = 0;
                else m_act = 0;
            end else if (m_age == 3) begin
                m_err = 1; m_act = 0;
            end else begin
                m_age++;
            end
        end
        if (do_push) mq.push_back(w & 'h3ff);
        #1;
    endtask

    task automatic apply_reset();
        resetn = 1'b0; run = 0; instr_valid = 0; instr_in = '0; done = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks += 7;
        if (t !== 2'd0)          begin errors++; $display("FAIL reset_t: got %0d expected 0", t); end
        if (instr !== 10'd0)     begin errors++; $display("FAIL reset_instr: got %0h expected 0", instr); end
        if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        if (err !== 1'b0)        begin errors++; $display("FAIL reset_err: got %0b expected 0", err); end
        if (retired !== 8'd0)    begin errors++; $display("FAIL reset_retired: got %0d expected 0", retired); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", instr_ready); end
    endtask

    task automatic test_load();
        apply_reset();
        cycle(1, 1, 'h000, 0);
        cycle(1, 0, 0, 0);
        checks += 2;
        if (t !== 2'd0 || busy !== 1'b1) begin errors++; $display("FAIL load_fetch: got t=%0d busy=%0b expected t=0 busy=1", t, busy); end
        if (instr !== 10'h000) begin errors++; $display("FAIL load_instr: got %0h expected 0", instr); end
        cycle(1, 0, 0, 0);
        checks++;
        if (t !== 2'd1) begin errors++; $display("FAIL load_t1: got %0d expected 1", t); end
        cycle(1, 0, 0, 1);
        checks += 2;
        if (t !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL load_idle: got t=%0d busy=%0b expected t=0 busy=0", t, busy); end
        if (retired !== 8'd1) begin errors++; $display("FAIL load_retired: got %0d expected 1", retired); end
    endtask

    task automatic test_immediate();
        apply_reset();
        cycle(1, 1, 'h205, 0);
        cycle(1, 0, 0, 0);
        checks++;
        if (t !== 2'd0 || instr !== 10'h205) begin errors++; $display("FAIL imm_fetch: got t=%0d instr=%0h expected t=0 instr=205", t, instr); end
        for (int k = 1; k <= 3; k++) begin
            cycle(1, 0, 0, 0);
            checks++;
            if (t !== 2'(k) || instr !== 10'h205) begin errors++; $display("FAIL imm_exec: got t=%0d instr=%0h expected t=%0d instr=205", t, instr, k); end
        end
        cycle(1, 0, 0, 1);
        checks++;
        if (retired !== 8'd1 || err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL imm_done: got retired=%0d err=%0b busy=%0b expected 1,0,0", retired, err, busy); end
    endtask

    task automatic test_fifo_full();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (instr_ready !== (i < 4)) begin errors++; $display("FAIL full_ready%0d: got %0b expected %0b", i, instr_ready, (i < 4)); end
            cycle(0, 1, 'h100 + i, 0);
        end
        checks++;
        if (fifo_count !== 3'd4 || instr_ready !== 1'b0) begin errors++; $display("FAIL full_count: got count=%0d ready=%0b expected 4,0", fifo_count, instr_ready); end
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (instr !== 10'('h100 + i) || busy !== 1'b1) begin errors++; $display("FAIL full_order%0d: got instr=%0h busy=%0b expected %0h,1", i, instr, busy, 'h100 + i); end
            cycle(1, 0, 0, 0);
            cycle(1, 0, 0, 1);
        end
        checks++;
        if (busy !== 1'b0 || fifo_count !== 3'd0 || retired !== 8'd4) begin errors++; $display("FAIL full_drain: got busy=%0b count=%0d retired=%0d expected 0,0,4", busy, fifo_count, retired); end
    endtask

    task automatic test_error();
        apply_reset();
        cycle(0, 1, 'h011, 0);
        cycle(0, 1, 'h022, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        repeat (3) cycle(1, 0, 0, 0);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || t !== 2'd0 || fifo_count !== 3'd1) begin
            errors++; $display("FAIL err_enter: got err=%0b busy=%0b t=%0d count=%0d expected 1,0,0,1", err, busy, t, fifo_count);
        end
        repeat (4) cycle(1, 0, 0, 1);
        checks++;
        if (err !== 1'b1 || fifo_count !== 3'd1 || retired !== 8'd0 || t !== 2'd0) begin
            errors++; $display("FAIL err_hold: got err=%0b count=%0d retired=%0d t=%0d expected 1,1,0,0", err, fifo_count, retired, t);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (err !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL err_clear: got err=%0b count=%0d expected 0,0", err, fifo_count); end
        m_reset();
        @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic test_run_drop();
        apply_reset();
        cycle(0, 1, 'h150, 0);
        cycle(0, 1, 'h0a1, 0);
        cycle(0, 1, 'h0a2, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        checks++;
        if (t !== 2'd2 || instr !== 10'h150) begin errors++; $display("FAIL drop_t2: got t=%0d instr=%0h expected 2,150", t, instr); end
        cycle(0, 0, 0, 0);
        checks++;
        if (t !== 2'd3 || busy !== 1'b1) begin errors++; $display("FAIL drop_continue: got t=%0d busy=%0b expected 3,1", t, busy); end
        cycle(0, 0, 0, 1);
        checks++;
        if (busy !== 1'b0 || fifo_count !== 3'd2 || retired !== 8'd1 || err !== 1'b0) begin
            errors++; $display("FAIL drop_idle: got busy=%0b count=%0d retired=%0d err=%0b expected 0,2,1,0", busy, fifo_count, retired, err);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        cycle(0, 1, 'h0c1, 0);
        cycle(0, 1, 'h0c2, 0);
        cycle(0, 1, 'h0c3, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        checks++;
        if (t !== 2'd2 || retired !== 8'd1 || fifo_count !== 3'd1) begin
            errors++; $display("FAIL areset_setup: got t=%0d retired=%0d count=%0d expected 2,1,1", t, retired, fifo_count);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (t !== 2'd0 || busy !== 1'b0 || instr !== 10'd0 || retired !== 8'd0 || fifo_count !== 3'd0 || instr_ready !== 1'b1) begin
            errors++; $display("FAIL areset_now: got t=%0d busy=%0b instr=%0h retired=%0d count=%0d ready=%0b expected 0,0,0,0,0,1",
                               t, busy, instr, retired, fifo_count, instr_ready);
        end
        m_reset();
        @(posedge clk);
        #1 resetn = 1'b1;
        repeat (3) cycle(1, 0, 0, 1);
        checks++;
        if (busy !== 1'b0 || retired !== 8'd0) begin errors++; $display("FAIL areset_discard: got busy=%0b retired=%0d expected 0,0", busy, retired); end
    endtask

    // Randomized traffic (stress=0) or saturated back-to-back traffic (stress=1).
    task automatic test_random(input int n, input bit stress);
        bit r, v, d;
        apply_reset();
        tgt = 1;
        for (int c = 0; c < n; c++) begin
            checks += 7;
            if (t !== 2'(exp_t()))            begin errors++; $display("FAIL rnd_t c%0d: got %0d expected %0d", c, t, exp_t()); end
            if (instr !== 10'(exp_instr()))   begin errors++; $display("FAIL rnd_instr c%0d: got %0h expected %0h", c, instr, exp_instr()); end
            if (busy !== m_act)               begin errors++; $display("FAIL rnd_busy c%0d: got %0b expected %0b", c, busy, m_act); end
            if (err !== m_err)                begin errors++; $display("FAIL rnd_err c%0d: got %0b expected %0b", c, err, m_err); end
            if (fifo_count !== 3'(mq.size())) begin errors++; $display("FAIL rnd_count c%0d: got %0d expected %0d", c, fifo_count, mq.size()); end
            if (retired !== 8'(m_ret))        begin errors++; $display("FAIL rnd_retired c%0d: got %0d expected %0d", c, retired, m_ret % 256); end
            if (instr_ready !== (mq.size() < 4)) begin errors++; $display("FAIL rnd_ready c%0d: got %0b expected %0b", c, instr_ready, (mq.size() < 4)); end
            if (m_act && m_age == 0) tgt = int'($urandom_range(1, 3));
            if (stress) begin
                r = 1; v = 1; d = 1;
            end else begin
                r = ($urandom % 8) != 0;
                v = ($urandom % 2) != 0;
                d = (m_act && m_age >= 1) ? (m_age >= tgt) : (($urandom % 2) != 0);
            end
            cycle(r, v, int'($urandom % 1024), d);
        end
    endtask

    task automatic test_retired_wrap();
        test_random(560, 1'b1);
        checks++;
        if (m_ret <= 256 || retired !== 8'(m_ret)) begin
            errors++; $display("FAIL wrap: got retired=%0d expected %0d after %0d retirements", retired, m_ret % 256, m_ret);
        end
    endtask

    initial begin
        resetn = 1'b0; run = 0; instr_valid = 0; instr_in = '0; done = 0;
        test_reset();
        test_load();
        test_immediate();
        test_fifo_full();
        test_error();
        test_run_drop();
        test_async_reset();
        test_random(600, 1'b0);
        test_retired_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port run, input, 1, level; 1 = fetch and execute queued instructions.
REQ-004 SHALL have port instr_in, input, 10, instruction word from the loader.
REQ-005 SHALL have port instr_valid, input, 1, instr_in is valid this cycle.
REQ-006 SHALL have port instr_ready, output, 1, queue can accept a word this cycle.
REQ-007 SHALL have port done, input, 1, completion flag from the control circuit.
REQ-008 SHALL have port instr, output, 10, instruction word driven to the control circuit.
REQ-009 SHALL have port t, output, 2, timestep driven to the control circuit.
REQ-010 SHALL have port busy, output, 1, high in FETCH or EXEC.
REQ-011 SHALL have port err, output, 1, sticky error: done missing by timestep 3.
REQ-012 SHALL have port fifo_count, output, 3, queue occupancy, 0..4.
REQ-013 SHALL have port retired, output, 8, count of completed instructions.

Function
REQ-014 SHALL buffer instructions in a 4-deep FIFO; push when instr_valid && instr_ready; instr_ready = (fifo_count < 4), independent of a same-cycle pop.
REQ-015 SHALL implement states IDLE, FETCH, EXEC, ERROR.
REQ-016 IDLE: t=00, instr=cur_instr; go to FETCH when run=1 and fifo_count>0.
REQ-017 FETCH (one cycle): t=00, instr=FIFO head (combinational); at the edge, pop head into cur_instr, then go to EXEC with t=01.
REQ-018 EXEC: instr=cur_instr; at each edge, if done=1, increment retired and go to FETCH when run=1 and fifo_count>0 after the pop, else IDLE; if done=0 and t<3, increment t.
REQ-019 EXEC with t=3 and done=0 SHALL go to ERROR; ERROR holds t=00 and err=1 until resetn; no pops occur while in ERROR.
REQ-020 Minimum latency SHALL be 2 cycles per instruction (LOAD/COPY: done at t=1); maximum is 4 (immediate ops: done at t=3).
REQ-021 Deasserting run mid-instruction SHALL NOT abort it; the instruction completes, then the block enters IDLE.
REQ-022 done SHALL be ignored in IDLE, FETCH and ERROR.
REQ-023 Simultaneous push and pop SHALL keep fifo_count unchanged; read and write pointers wrap modulo 4.
REQ-024 retired SHALL wrap from 255 to 0.
REQ-025 t SHALL be registered with no combinational path from done to t.

Reset
REQ-026 resetn=0 SHALL asynchronously force:
- state=IDLE, t=00
- cur_instr=0, instr=0
- FIFO empty (fifo_count=0, pointers 0)
- err=0, retired=0, busy=0
- instr_ready=1
REQ-027 Reset mid-instruction SHALL discard the in-flight instruction and all queued instructions.

Structure
REQ-028 SHALL place the following in a shared package:
- state enum
- FIFO depth 4
- instruction width 10
- timestep constants T0..T3
- maximum timestep 3
REQ-029 SHALL implement the FIFO as sub-module instr_fifo with push/pop/count ports; the FSM and counters reside in instr_sequencer.

Verification
REQ-030 Stimulus: push LOAD 0x000 with run=1; done at t=1. Response: t sequence 00,01,00; retired=1; back to IDLE.
REQ-031 Stimulus: push immediate 0x205; done at t=3. Response: t sequence 00,01,10,11; instr=0x205 from FETCH through the last EXEC cycle.
REQ-032 Stimulus: push 5 words back-to-back with run=0. Response: instr_ready=0 after the 4th; fifo_count=4; 5th not accepted.
REQ-033 Stimulus: withhold done for 3 EXEC cycles. Response: err=1, state ERROR, fifo_count frozen; resetn clears err.
REQ-034 Stimulus: drop run during t=2 of an ADD with 2 words queued. Response: ADD retires, IDLE entered, fifo_count=2.
REQ-035 Stimulus: pulse resetn low during EXEC t=2. Response: outputs take reset values immediately, without waiting for a clock edge.
